// File: rtl/fcs_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fcs_ctrl_pkg
// Shared definitions for the Ethernet FCS receive controller:
//   - controller state encoding
//   - default legal frame-length limits (FCS included)
//   - delay-line depth and length-counter width
//   - CRC-32 constants and a byte-wide reflected CRC-32 update helper
// -----------------------------------------------------------------------------
package fcs_ctrl_pkg;

   localparam int MIN_LEN_DEFAULT = 64;
   localparam int MAX_LEN_DEFAULT = 1518;
   localparam int DLY_DEPTH       = 4;
   localparam int LEN_W           = 11;

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   // Register value left after running data plus its own (inverted) FCS
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_RUN    = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RESULT = 3'd4,
      ST_ABORT  = 3'd5
   } state_t;

   // LSB-first CRC-32 update over one byte
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'd0, data};
      for (int b = 0; b < 8; b++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/fcs_check_parallel.sv
// -----------------------------------------------------------------------------
// fcs_check_parallel
// Byte-parallel CRC-32 frame checker. Runs the CRC over every byte of the
// frame including the trailing FCS and flags an error unless the register
// ends on the CRC-32 residue after an end_of_frame was seen.
// Ports:
//   i_clk        clock
//   i_rst        asynchronous active-high reset
//   i_sof        first byte of a frame (restarts the CRC)
//   i_eof        first FCS byte of the frame
//   i_valid      i_data is a frame byte this cycle
//   i_data       frame byte
//   o_fcs_error  1 unless the bytes seen so far form a complete, valid frame
// -----------------------------------------------------------------------------
module fcs_check_parallel
   import fcs_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sof,
   input  logic       i_eof,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_fcs_error
);

   logic [31:0] r_crc;
   logic        r_seen_eof;
   logic        r_fcs_error;
   logic [31:0] w_crc_nxt;
   logic        w_seen_nxt;

   // Next CRC / end-of-frame tracking for the byte on the input
   always_comb begin
      w_crc_nxt  = r_crc;
      w_seen_nxt = r_seen_eof;
      if (i_valid) begin
         w_crc_nxt  = crc32_byte(i_sof ? CRC_INIT : r_crc, i_data);
         w_seen_nxt = i_eof | (r_seen_eof & ~i_sof);
      end else begin
         w_crc_nxt  = r_crc;
         w_seen_nxt = r_seen_eof;
      end
   end

   // CRC state and registered verdict
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_crc       <= CRC_INIT;
         r_seen_eof  <= 1'b0;
         r_fcs_error <= 1'b1;
      end else begin
         r_crc       <= w_crc_nxt;
         r_seen_eof  <= w_seen_nxt;
         r_fcs_error <= ~(w_seen_nxt && (w_crc_nxt == CRC_RESIDUE));
      end
   end

   assign o_fcs_error = r_fcs_error;

endmodule

// File: rtl/fcs_rx_ctrl.sv
// -----------------------------------------------------------------------------
// fcs_rx_ctrl
// Receive-side FCS controller. Buffers incoming bytes in a 4-deep delay line
// so the trailing FCS never reaches the payload output, feeds the frame to
// fcs_check_parallel, forwards the payload and reports a per-frame status.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_last     input byte stream (FCS last), rx_ready back
//   out_valid/out_data/out_last  payload stream with FCS stripped
//   stat_valid                   one-cycle status pulse
//   stat_fcs_ok/stat_len_err/stat_abort/stat_len  status, held until next pulse
// -----------------------------------------------------------------------------
module fcs_rx_ctrl
   import fcs_ctrl_pkg::*;
#(
   parameter int MIN_LEN = MIN_LEN_DEFAULT,
   parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   input  logic             rx_last,
   output logic             rx_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             stat_valid,
   output logic             stat_fcs_ok,
   output logic             stat_len_err,
   output logic             stat_abort,
   output logic [LEN_W-1:0] stat_len
);

   state_t                    r_state;
   logic [DLY_DEPTH-1:0][7:0] r_dly;
   logic [LEN_W-1:0]          r_len;
   logic [1:0]                r_drain_cnt;
   logic                      r_fwd;
   logic                      r_chk_clr;
   logic                      r_rx_ready;
   logic                      r_out_valid;
   logic [7:0]                r_out_data;
   logic                      r_out_last;
   logic                      r_stat_valid;
   logic                      r_stat_fcs_ok;
   logic                      r_stat_len_err;
   logic                      r_stat_abort;
   logic [LEN_W-1:0]          r_stat_len;

   logic             w_accept;
   logic             w_at_byte4;
   logic             w_feed;
   logic             w_sof;
   logic             w_eof;
   logic             w_payload;
   logic             w_fcs_error;
   logic             w_chk_rst;
   logic             w_len_err;
   logic [7:0]       w_feed_data;
   logic [LEN_W-1:0] w_len_inc;

   assign w_accept    = rx_valid & r_rx_ready;
   // r_len equals the index of the byte currently on the input
   assign w_at_byte4  = (r_len == LEN_W'(DLY_DEPTH));
   assign w_len_inc   = (r_len == {LEN_W{1'b1}}) ? r_len : (r_len + 11'd1);
   assign w_len_err   = (int'(r_len) < MIN_LEN) || (int'(r_len) > MAX_LEN);
   assign w_feed_data = r_dly[DLY_DEPTH-1];
   assign w_chk_rst   = ~reset_n | r_chk_clr;

   // Checker feed decode: delayed byte goes in while filling past byte 4,
   // while running, and for the four buffered FCS bytes while draining
   always_comb begin
      w_feed    = 1'b0;
      w_sof     = 1'b0;
      w_eof     = 1'b0;
      w_payload = 1'b0;
      case (r_state)
         ST_FILL: begin
            w_feed    = w_accept & w_at_byte4;
            w_sof     = w_accept & w_at_byte4;
            w_payload = w_accept & w_at_byte4;
         end
         ST_RUN: begin
            w_feed    = w_accept;
            w_payload = w_accept;
         end
         ST_DRAIN: begin
            w_feed = 1'b1;
            w_eof  = (r_drain_cnt == 2'd0);
         end
         default: begin
            w_feed = 1'b0;
         end
      endcase
   end

   fcs_check_parallel u_chk (
      .i_clk       (clk),
      .i_rst       (w_chk_rst),
      .i_sof       (w_sof),
      .i_eof       (w_eof),
      .i_valid     (w_feed),
      .i_data      (w_feed_data),
      .o_fcs_error (w_fcs_error)
   );

   // Controller FSM, delay line, counters and all registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_dly          <= '0;
         r_len          <= '0;
         r_drain_cnt    <= 2'd0;
         r_fwd          <= 1'b0;
         r_chk_clr      <= 1'b0;
         r_rx_ready     <= 1'b1;
         r_out_valid    <= 1'b0;
         r_out_data     <= 8'd0;
         r_out_last     <= 1'b0;
         r_stat_valid   <= 1'b0;
         r_stat_fcs_ok  <= 1'b0;
         r_stat_len_err <= 1'b0;
         r_stat_abort   <= 1'b0;
         r_stat_len     <= '0;
      end else begin
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_stat_valid <= 1'b0;
         r_chk_clr    <= 1'b0;

         if (w_accept) begin
            r_dly <= {r_dly[DLY_DEPTH-2:0], rx_data};
         end else if (r_state == ST_DRAIN) begin
            r_dly <= {r_dly[DLY_DEPTH-2:0], 8'd0};
         end else begin
            r_dly <= r_dly;
         end

         if (w_payload) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_feed_data;
            r_out_last  <= rx_last;
            r_fwd       <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               r_fwd <= 1'b0;
               if (w_accept) begin
                  r_len <= 11'd1;
                  if (rx_last) begin
                     r_state    <= ST_ABORT;
                     r_rx_ready <= 1'b0;
                     r_chk_clr  <= 1'b1;
                  end else begin
                     r_state <= ST_FILL;
                  end
               end
            end
            ST_FILL, ST_RUN: begin
               if (!rx_valid) begin
                  r_state    <= ST_ABORT;
                  r_rx_ready <= 1'b0;
                  r_chk_clr  <= 1'b1;
               end else begin
                  r_len <= w_len_inc;
                  if (rx_last && (r_state == ST_FILL) && !w_at_byte4) begin
                     // runt: the FCS alone would not fit
                     r_state    <= ST_ABORT;
                     r_rx_ready <= 1'b0;
                     r_chk_clr  <= 1'b1;
                  end else if (rx_last) begin
                     r_state     <= ST_DRAIN;
                     r_rx_ready  <= 1'b0;
                     r_drain_cnt <= 2'd0;
                  end else if (w_at_byte4) begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_drain_cnt == 2'd3) begin
                  r_state <= ST_RESULT;
               end else begin
                  r_drain_cnt <= r_drain_cnt + 2'd1;
               end
            end
            ST_RESULT: begin
               r_stat_valid   <= 1'b1;
               r_stat_fcs_ok  <= ~w_fcs_error;
               r_stat_len_err <= w_len_err;
               r_stat_abort   <= 1'b0;
               r_stat_len     <= r_len;
               r_state        <= ST_IDLE;
               r_rx_ready     <= 1'b1;
            end
            ST_ABORT: begin
               r_stat_valid   <= 1'b1;
               r_stat_fcs_ok  <= 1'b0;
               r_stat_len_err <= w_len_err;
               r_stat_abort   <= 1'b1;
               r_stat_len     <= r_len;
               // terminate a partially forwarded payload with a marker beat
               r_out_valid    <= r_fwd;
               r_out_last     <= r_fwd;
               r_out_data     <= 8'd0;
               r_fwd          <= 1'b0;
               r_state        <= ST_IDLE;
               r_rx_ready     <= 1'b1;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_rx_ready <= 1'b1;
            end
         endcase
      end
   end

   assign rx_ready     = r_rx_ready;
   assign out_valid    = r_out_valid;
   assign out_data     = r_out_data;
   assign out_last     = r_out_last;
   assign stat_valid   = r_stat_valid;
   assign stat_fcs_ok  = r_stat_fcs_ok;
   assign stat_len_err = r_stat_len_err;
   assign stat_abort   = r_stat_abort;
   assign stat_len     = r_stat_len;

endmodule

// File: tb/tb_fcs_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fcs_rx_ctrl
// Directed, table-driven bench for fcs_rx_ctrl. Frames are built with an
// FCS computed here bit-serially; each table row gives the expected status
// and payload count. Back-to-back and reset-mid-frame are hand sequences.
// -----------------------------------------------------------------------------
module tb_fcs_rx_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_last = 1'b0;
   logic        rx_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        stat_valid;
   logic        stat_fcs_ok;
   logic        stat_len_err;
   logic        stat_abort;
   logic [10:0] stat_len;

   fcs_rx_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_last      (rx_last),
      .rx_ready     (rx_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .stat_valid   (stat_valid),
      .stat_fcs_ok  (stat_fcs_ok),
      .stat_len_err (stat_len_err),
      .stat_abort   (stat_abort),
      .stat_len     (stat_len)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // monitor records
   logic [7:0]  mon_data [0:8191];
   logic        mon_last [0:8191];
   int          mon_n = 0;
   logic        st_ok   [0:15];
   logic        st_lerr [0:15];
   logic        st_abrt [0:15];
   logic [10:0] st_len  [0:15];
   int          st_cyc  [0:15];
   int          st_cnt = 0;

   always @(negedge clk) begin
      if (out_valid && mon_n < 8192) begin
         mon_data[mon_n] = out_data;
         mon_last[mon_n] = out_last;
         mon_n = mon_n + 1;
      end
      if (stat_valid) begin
         st_ok[st_cnt & 15]   = stat_fcs_ok;
         st_lerr[st_cnt & 15] = stat_len_err;
         st_abrt[st_cnt & 15] = stat_abort;
         st_len[st_cnt & 15]  = stat_len;
         st_cyc[st_cnt & 15]  = cyc;
         st_cnt = st_cnt + 1;
      end
   end

   logic [7:0] fr [0:2047];

   typedef struct {
      int   n;
      int   flip;
      int   stop;
      logic ok;
      int   len;
      logic lerr;
      logic abrt;
      int   nout;
   } vec_t;

   vec_t vt [0:8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // bit-serial reflected CRC-32 over fr[0..n-1]
   function automatic logic [31:0] tb_crc(input int n);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[0] ^ fr[i][b];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB8_8320;
         end
      end
      return c;
   endfunction

   task automatic build(input int n, input int flip, input int seed);
      logic [31:0] fcs;
      for (int i = 0; i < n; i++) fr[i] = 8'((i * 13) + (seed * 7) + 1);
      if (n >= 5) begin
         fcs = ~tb_crc(n - 4);
         for (int j = 0; j < 4; j++) fr[n - 4 + j] = fcs[8*j +: 8];
      end
      if (flip >= 0) fr[flip] = fr[flip] ^ 8'h04;
   endtask

   // drives bytes on negedges, honouring rx_ready; stop_at inserts a gap there
   task automatic send(input int n, input int stop_at, output int lcyc, output int first_wait);
      int w;
      lcyc = 0;
      first_wait = 0;
      for (int i = 0; i < n; i++) begin
         w = 0;
         @(negedge clk);
         if (i == stop_at) begin
            rx_valid = 1'b0;
            rx_last  = 1'b0;
            break;
         end
         while (!rx_ready && w < 50) begin
            rx_valid = 1'b0;
            rx_last  = 1'b0;
            w = w + 1;
            @(negedge clk);
         end
         if (w >= 50) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL ready_timeout: rx_ready stayed 0 for %0d cycles, required 1", w);
         end
         if (i == 0) first_wait = w;
         rx_valid = 1'b1;
         rx_data  = fr[i];
         rx_last  = (i == n - 1);
         if (i == n - 1) lcyc = cyc;
      end
   endtask

   task automatic count_busy(output int c);
      c = 0;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      while (!rx_ready && c < 20) begin
         c = c + 1;
         @(negedge clk);
      end
   endtask

   task automatic wait_stat(input int target);
      int t;
      t = 0;
      while (st_cnt < target && t < 60) begin
         @(negedge clk);
         t = t + 1;
      end
      chk("stat_arrived", 32'(st_cnt >= target), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int seed);
      int bm, bs, lcyc, w, nl, bad, ndata, k;
      build(v.n, v.flip, seed);
      bm = mon_n;
      bs = st_cnt;
      send(v.n, v.stop, lcyc, w);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      wait_stat(bs + 1);
      repeat (3) @(negedge clk);
      k = bs & 15;
      chk($sformatf("n%0d_stat_pulses", v.n), 32'(st_cnt - bs), 32'd1);
      chk($sformatf("n%0d_fcs_ok", v.n), 32'(st_ok[k]), 32'(v.ok));
      chk($sformatf("n%0d_len", v.n), 32'(st_len[k]), 32'(v.len));
      chk($sformatf("n%0d_len_err", v.n), 32'(st_lerr[k]), 32'(v.lerr));
      chk($sformatf("n%0d_abort", v.n), 32'(st_abrt[k]), 32'(v.abrt));
      chk($sformatf("n%0d_out_count", v.n), 32'(mon_n - bm), 32'(v.nout));
      if (v.nout > 0 && mon_n - bm == v.nout) begin
         nl = 0;
         bad = 0;
         ndata = v.abrt ? v.nout - 1 : v.nout;
         for (int j = 0; j < v.nout; j++) nl = nl + int'(mon_last[bm + j]);
         for (int j = 0; j < ndata; j++) if (mon_data[bm + j] !== fr[j]) bad = bad + 1;
         chk($sformatf("n%0d_out_last_count", v.n), 32'(nl), 32'd1);
         chk($sformatf("n%0d_out_last_final", v.n), 32'(mon_last[bm + v.nout - 1]), 32'd1);
         chk($sformatf("n%0d_out_data_bad", v.n), 32'(bad), 32'd0);
      end
      if (!v.abrt) chk($sformatf("n%0d_latency", v.n), 32'(st_cyc[k] - lcyc), 32'd6);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int l1, l2, w1, w2, c, bs, k0, k1;
      vec_t vg;
      //         n     flip  stop  ok    len   lerr  abrt  nout
      vt[0] = '{64,   -1,   -1,   1'b1, 64,   1'b0, 1'b0, 60};
      vt[1] = '{64,   10,   -1,   1'b0, 64,   1'b0, 1'b0, 60};
      vt[2] = '{64,   -1,   30,   1'b0, 30,   1'b1, 1'b1, 27};
      vt[3] = '{64,   -1,   -1,   1'b1, 64,   1'b0, 1'b0, 60};
      vt[4] = '{3,    -1,   -1,   1'b0, 3,    1'b1, 1'b1, 0};
      vt[5] = '{20,   -1,   -1,   1'b1, 20,   1'b1, 1'b0, 16};
      vt[6] = '{1518, -1,   -1,   1'b1, 1518, 1'b0, 1'b0, 1514};
      vt[7] = '{1519, -1,   -1,   1'b1, 1519, 1'b1, 1'b0, 1515};
      vt[8] = '{63,   -1,   -1,   1'b1, 63,   1'b1, 1'b0, 59};

      #2 reset_n = 1'b0;
      #2;
      chk("reset_rx_ready", 32'(rx_ready), 32'd1);
      chk("reset_outputs", 32'({out_valid, out_last, out_data, stat_valid, stat_fcs_ok,
                                stat_len_err, stat_abort, stat_len}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 9; v++) run_vec(vt[v], v);

      // back-to-back good frames
      bs = st_cnt;
      build(64, -1, 21);
      send(64, -1, l1, w1);
      build(64, -1, 22);
      send(64, -1, l2, w2);
      chk("b2b_busy_after_first", 32'(w2), 32'd5);
      count_busy(c);
      chk("b2b_busy_after_second", 32'(c), 32'd5);
      wait_stat(bs + 2);
      k0 = bs & 15;
      k1 = (bs + 1) & 15;
      chk("b2b_first_ok", 32'(st_ok[k0]), 32'd1);
      chk("b2b_second_ok", 32'(st_ok[k1]), 32'd1);
      chk("b2b_first_latency", 32'(st_cyc[k0] - l1), 32'd6);
      chk("b2b_second_latency", 32'(st_cyc[k1] - l2), 32'd6);
      repeat (3) @(negedge clk);

      // reset asserted at byte 40
      build(64, -1, 31);
      bs = st_cnt;
      send(64, 40, l1, w1);
      reset_n = 1'b0;
      #2;
      chk("midreset_outputs", 32'({out_valid, out_last, out_data, stat_valid, stat_fcs_ok,
                                   stat_len_err, stat_abort, stat_len}), 32'd0);
      chk("midreset_rx_ready", 32'(rx_ready), 32'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("midreset_no_stat", 32'(st_cnt), 32'(bs));
      vg = '{64, -1, -1, 1'b1, 64, 1'b0, 1'b0, 60};
      run_vec(vg, 40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fcs_rx_ctrl.md
FCS_RX_CTRL -- requirements
Module: fcs_rx_ctrl

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64: minimum legal frame length in bytes, FCS included.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum legal frame length in bytes, FCS included.
REQ-003 SHALL use a single clock and an asynchronous, active-low reset.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  input byte valid.
- rx_data  in  8  input byte; frame bytes in order, FCS last.
- rx_last  in  1  marks the final FCS byte.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- out_valid  out  1  payload byte valid; FCS stripped.
- out_data  out  8  payload byte.
- out_last  out  1  final payload byte.
- stat_valid  out  1  one-cycle frame status pulse.
- stat_fcs_ok  out  1  FCS check passed.
- stat_len_err  out  1  length below MIN_LEN or above MAX_LEN.
- stat_abort  out  1  frame aborted by an input gap or a runt below 5 bytes.
- stat_len  out  11  bytes received, saturating at 2047.

Function
REQ-005 SHALL sequence one instance of fcs_check_parallel:
- start_of_frame on the first byte fed to it.
- end_of_frame on the first FCS byte fed to it.
- A contiguous byte on every cycle in between.
REQ-006 SHALL hold input bytes in a 4-entry delay line, so the checker and output see byte i-4 when input byte i is accepted.
REQ-007 SHALL implement states IDLE, FILL, RUN, DRAIN, RESULT, ABORT; rx_ready SHALL be 1 in IDLE, FILL and RUN, and 0 otherwise.
REQ-008 IDLE->FILL SHALL occur on the first accepted byte; FILL collects bytes 0..3 and does not feed the checker.
REQ-009 FILL->RUN SHALL occur on accepting byte 4; from then on, each accepted byte feeds delayed byte i-4 to the checker, with start_of_frame on byte 0.
REQ-010 RUN->DRAIN SHALL occur on accepted rx_last.
- DRAIN lasts exactly 4 cycles and feeds the 4 buffered FCS bytes.
- end_of_frame is asserted in the first DRAIN cycle.
REQ-011 DRAIN->RESULT SHALL occur after the 4th DRAIN cycle; RESULT lasts 1 cycle and samples checker fcs_error into stat_fcs_ok = ~fcs_error.
REQ-012 stat_valid SHALL pulse in the cycle after RESULT, and the block SHALL return to IDLE in that same cycle.
- Latency: rx_last accepted at cycle L -> stat_valid at L+6.
REQ-013 Payload bytes (every byte fed to the checker before end_of_frame) SHALL appear on out_* registered, one cycle after they are fed.
- out_last is set on the byte fed in the cycle rx_last is accepted.
REQ-014 rx_valid=0 in FILL or RUN SHALL be treated as a gap and cause the transition to ABORT.
REQ-015 ABORT SHALL last 1 cycle and SHALL:
- pulse the checker's active-high reset;
- emit stat_valid with stat_abort=1, stat_fcs_ok=0;
- emit out_valid=1 with out_last=1 and no data meaning, if any payload was already forwarded;
- return to IDLE.
REQ-016 rx_last accepted in FILL (frame shorter than 5 bytes) SHALL take the ABORT path with stat_len_err=1.
REQ-017 stat_len SHALL count accepted bytes from first byte through rx_last, saturating at 2047.
- stat_len_err = (stat_len < MIN_LEN) || (stat_len > MAX_LEN).
- A length error SHALL NOT stop FCS checking.
REQ-018 Status outputs SHALL hold their values until the next stat_valid.
- stat_valid, out_valid and out_last SHALL be 0 whenever no pulse or byte is being presented.

Reset
REQ-019 reset_n low SHALL immediately set:
- state to IDLE, rx_ready to 1, delay line to 0, counters to 0;
- all out_* and stat_* outputs to 0.
REQ-020 The checker's reset SHALL be driven as ~reset_n OR the ABORT clear.
REQ-021 Reset mid-frame SHALL discard the frame without a stat_valid pulse.

Structure
REQ-022 Package fcs_ctrl_pkg SHALL hold:
- the state enum;
- MIN_LEN and MAX_LEN defaults;
- the delay depth constant (4);
- the length width constant (11).
REQ-023 fcs_check_parallel SHALL be the only sub-module; delay line, counters and FSM SHALL be local.

Verification
REQ-024 A 64-byte frame with correct FCS, contiguous -> 60 out bytes with out_last on the 60th, stat_valid at L+6, fcs_ok=1, len=64, len_err=0, abort=0.
REQ-025 The same frame with one payload bit flipped -> fcs_ok=0, len=64, len_err=0.
REQ-026 rx_valid dropped for 1 cycle at byte 30 -> ABORT, stat_valid with abort=1 and fcs_ok=0; a following good 64-byte frame -> fcs_ok=1.
REQ-027 A 3-byte frame -> abort=1, len_err=1, len=3, no out bytes; a 20-byte frame with valid FCS -> fcs_ok=1, len_err=1.
REQ-028 Back-to-back good 64-byte frames -> rx_ready=0 for exactly 5 cycles after each rx_last (DRAIN plus RESULT); both frames report fcs_ok=1.
REQ-029 reset_n asserted at byte 40 -> all outputs 0 and no stat_valid; a following good frame -> fcs_ok=1.
